// File: rtl/capture_ctrl_if.sv
// Port bundle between capture_ctrl and its neighbours: command decoder/trigger,
// sampler, sample RAM and UART transmitter.
interface capture_ctrl_if #(
  parameter int DEPTH  = 5,
  parameter int GROUPS = 4
);
  localparam int SW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  logic              set_cnt_i;
  logic              set_flg_i;
  logic [31:0]       cmd_i;
  logic              run_i;
  logic              stb_i;
  logic              we_o;
  logic [DEPTH-1:0]  addr_o;
  // tx_stb_o pulses for one cycle only while tx_rdy_i is high, never two cycles
  // in a row; the byte (group tx_sel_o at addr_o) is taken in that cycle.
  logic              tx_rdy_i;
  logic              tx_stb_o;
  logic [SW-1:0]     tx_sel_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        state_o;

  modport slave (
    input  set_cnt_i, set_flg_i, cmd_i, run_i, stb_i, tx_rdy_i,
    output we_o, addr_o, tx_stb_o, tx_sel_o, busy_o, done_o, state_o
  );

  modport master (
    output set_cnt_i, set_flg_i, cmd_i, run_i, stb_i, tx_rdy_i,
    input  we_o, addr_o, tx_stb_o, tx_sel_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/capture_ctrl.sv
// Ring-buffer capture with post-trigger delay, then newest-first readout of
// each sample as enabled byte groups to the transmitter.
module capture_ctrl #(
  parameter int DEPTH  = 5,
  parameter int GROUPS = 4
) (
  input  logic           clk_i,
  input  logic           rst_in,
  capture_ctrl_if.slave  bus
);
  localparam int SW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [17:0] RD_MAX = 18'((1 << DEPTH) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RADDR, S_SEND} state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [17:0]        dly_q, dly_d, rd_q, rd_d;
  logic [15:0]        read_cfg_q, read_cfg_d, delay_cfg_q, delay_cfg_d;
  logic [GROUPS-1:0]  mask_q, mask_d;
  logic [SW-1:0]      grp_q, grp_d, sel_q, sel_d;
  logic               stb_last_q, stb_last_d, done_q, done_d;

  logic               we, tx_stb, any_en, has_next;
  logic [SW-1:0]      first_en, next_en;
  logic [17:0]        read_raw, read_m1, delay_m1;

  // Counters hold "remaining - 1" so (0xFFFF+1)*4 still fits in 18 bits.
  assign read_raw = {read_cfg_q, 2'b11};
  assign read_m1  = (read_raw > RD_MAX) ? RD_MAX : read_raw;
  assign delay_m1 = {delay_cfg_q, 2'b11};

  always_comb begin
    any_en   = 1'b0;
    has_next = 1'b0;
    first_en = '0;
    next_en  = '0;
    for (int i = GROUPS - 1; i >= 0; i--) begin
      if (!mask_q[i]) begin
        any_en   = 1'b1;
        first_en = SW'(i);
        if (i > int'(grp_q)) begin
          has_next = 1'b1;
          next_en  = SW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    dly_d       = dly_q;
    rd_d        = rd_q;
    read_cfg_d  = read_cfg_q;
    delay_cfg_d = delay_cfg_q;
    mask_d      = mask_q;
    grp_d       = grp_q;
    sel_d       = sel_q;
    done_d      = 1'b0;
    we          = 1'b0;
    tx_stb      = 1'b0;
    case (state_q)
      S_IDLE: begin
        we = bus.stb_i;
        if (bus.stb_i) wptr_d = wptr_q + 1'b1;
        if (bus.set_cnt_i) begin
          read_cfg_d  = bus.cmd_i[15:0];
          delay_cfg_d = bus.cmd_i[31:16];
        end
        if (bus.set_flg_i) mask_d = bus.cmd_i[GROUPS+1:2];
        if (bus.run_i) begin
          state_d = S_DELAY;
          dly_d   = bus.stb_i ? delay_m1 - 18'd1 : delay_m1;
        end
      end
      S_DELAY: begin
        we = bus.stb_i;
        if (bus.stb_i) begin
          wptr_d = wptr_q + 1'b1;
          if (dly_q == 18'd0) begin
            state_d = S_RADDR;
            rptr_d  = wptr_q;
            rd_d    = read_m1;
          end else begin
            dly_d = dly_q - 18'd1;
          end
        end
      end
      S_RADDR: begin
        grp_d   = first_en;
        state_d = S_SEND;
      end
      default: begin
        if (any_en && bus.tx_rdy_i && !stb_last_q) begin
          tx_stb = 1'b1;
          sel_d  = grp_q;
          if (has_next) grp_d = next_en;
        end
        if (!any_en || (tx_stb && !has_next)) begin
          rptr_d = rptr_q - 1'b1;
          if (rd_q == 18'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            rd_d    = rd_q - 18'd1;
            state_d = S_RADDR;
          end
        end
      end
    endcase
    stb_last_d = tx_stb;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      dly_q       <= '0;
      rd_q        <= '0;
      read_cfg_q  <= '0;
      delay_cfg_q <= '0;
      mask_q      <= '0;
      grp_q       <= '0;
      sel_q       <= '0;
      stb_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      dly_q       <= dly_d;
      rd_q        <= rd_d;
      read_cfg_q  <= read_cfg_d;
      delay_cfg_q <= delay_cfg_d;
      mask_q      <= mask_d;
      grp_q       <= grp_d;
      sel_q       <= sel_d;
      stb_last_q  <= stb_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.we_o     = we;
  assign bus.addr_o   = (state_q == S_RADDR || state_q == S_SEND) ? rptr_q : wptr_q;
  assign bus.tx_stb_o = tx_stb;
  assign bus.tx_sel_o = tx_stb ? grp_q : sel_q;
  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = done_q;
  assign bus.state_o  = state_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: write counting, readout byte order against
// an expected queue, transmitter pacing and asynchronous reset.
module tb_capture_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy_q = 1'b1;
  logic rdy_rand = 1'b0;
  logic prev_stb = 1'b0;
  logic [1:0] last_sel = '0;
  logic mon_en = 1'b0;

  int total = 0;
  int bad = 0;
  int n_wr = 0, n_dly_wr = 0, n_busy = 0, n_done = 0, n_stb = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  capture_ctrl_if #(.DEPTH(5), .GROUPS(4)) bus ();
  capture_ctrl #(.DEPTH(5), .GROUPS(4)) dut (.clk_i(clk), .rst_in(rst_n), .bus(bus));

  assign bus.tx_rdy_i = rdy_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy the cycle after a strobe, otherwise optionally random.
  always begin
    @(posedge clk);
    #1;
    rdy_q = rdy_rand ? (prev_stb ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.we_o) n_wr++;
    if (bus.we_o && bus.busy_o) n_dly_wr++;
    if (bus.busy_o) n_busy++;
    if (bus.done_o) n_done++;
    if (bus.tx_stb_o) begin
      n_stb++;
      check("stb_rdy", 32'(bus.tx_rdy_i), 32'd1);
      check("stb_b2b", 32'(prev_stb), 32'd0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("tx_byte", (32'(bus.addr_o) << 8) | 32'(bus.tx_sel_o), e);
      last_sel = bus.tx_sel_o;
    end else if (mon_en) begin
      check("sel_hold", 32'(bus.tx_sel_o), 32'(last_sel));
    end
    prev_stb = bus.tx_stb_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input int rd, input int dl);
    bus.cmd_i = {16'(dl), 16'(rd)};
    bus.set_cnt_i = 1'b1;
    tick();
    bus.set_cnt_i = 1'b0;
  endtask

  task automatic set_flg(input logic [3:0] m);
    bus.cmd_i = 32'(m) << 2;
    bus.set_flg_i = 1'b1;
    tick();
    bus.set_flg_i = 1'b0;
  endtask

  task automatic stb_n(input int n);
    bus.stb_i = 1'b1;
    repeat (n) tick();
    bus.stb_i = 1'b0;
  endtask

  task automatic run_then(input int n);
    bus.run_i = 1'b1;
    tick();
    bus.run_i = 1'b0;
    stb_n(n);
  endtask

  task automatic run_stb(input int n);
    bus.run_i = 1'b1;
    bus.stb_i = 1'b1;
    tick();
    bus.run_i = 1'b0;
    repeat (n - 1) tick();
    bus.stb_i = 1'b0;
  endtask

  task automatic push_read(input int top, input int nsamp, input logic [3:0] mask);
    for (int s = 0; s < nsamp; s++)
      for (int g = 0; g < 4; g++)
        if (!mask[g]) exp_q.push_back((32'((top - s) & 31) << 8) | 32'(g));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(n_done != d0), 32'd1);
    repeat (4) tick();
    check({tag, "_once"}, 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    int w0, d0, s0, b0, k;
    bus.set_cnt_i = 1'b0;
    bus.set_flg_i = 1'b0;
    bus.cmd_i = '0;
    bus.run_i = 1'b0;
    bus.stb_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_we", 32'(bus.we_o), 32'd0);
    check("rst_txstb", 32'(bus.tx_stb_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_addr", 32'(bus.addr_o), 32'd0);
    check("rst_sel", 32'(bus.tx_sel_o), 32'd0);
    mon_en = 1'b1;

    // Basic capture and readout: writes 0..9 pre-trigger, 10..13 post.
    set_cnt(1, 0);
    stb_n(10);
    check("t2_pre_addr", 32'(bus.addr_o), 32'd10);
    w0 = n_wr; d0 = n_dly_wr; s0 = n_stb;
    push_read(13, 8, 4'b0000);
    run_then(4);
    wait_done("t2_done", 400);
    check("t2_dly_wr", 32'(n_dly_wr - d0), 32'd4);
    check("t2_wr", 32'(n_wr - w0), 32'd4);
    check("t2_nstb", 32'(n_stb - s0), 32'd32);
    check("t2_q", 32'(exp_q.size()), 32'd0);
    check("t2_wptr", 32'(bus.addr_o), 32'd14);

    // Groups 0 and 2 disabled; stb held through part of the readout.
    set_flg(4'b0101);
    d0 = n_dly_wr; s0 = n_stb;
    push_read(17, 8, 4'b0101);
    run_then(4);
    stb_n(20);
    wait_done("t3_done", 400);
    check("t3_dly_wr", 32'(n_dly_wr - d0), 32'd4);
    check("t3_nstb", 32'(n_stb - s0), 32'd16);
    check("t3_q", 32'(exp_q.size()), 32'd0);
    check("t3_wptr", 32'(bus.addr_o), 32'd18);

    // Read count clamped to 32 samples; address wraps 0 -> 31.
    set_cnt(15, 0);
    set_flg(4'b0000);
    s0 = n_stb;
    push_read(21, 32, 4'b0000);
    run_then(4);
    wait_done("t4_done", 2000);
    check("t4_nstb", 32'(n_stb - s0), 32'd128);
    check("t4_q", 32'(exp_q.size()), 32'd0);

    // run with stb in the same cycle; set_cnt during DELAY is ignored.
    set_cnt(0, 0);
    w0 = n_wr; s0 = n_stb;
    push_read(25, 4, 4'b0000);
    bus.run_i = 1'b1;
    bus.stb_i = 1'b1;
    tick();
    bus.run_i = 1'b0;
    bus.stb_i = 1'b0;
    set_cnt(3, 5);
    stb_n(3);
    wait_done("t5_done", 400);
    check("t5_wr", 32'(n_wr - w0), 32'd4);
    check("t5_nstb", 32'(n_stb - s0), 32'd16);
    check("t5_q", 32'(exp_q.size()), 32'd0);

    // Random transmitter readiness.
    set_cnt(1, 0);
    rdy_rand = 1'b1;
    s0 = n_stb;
    push_read(29, 8, 4'b0000);
    run_then(4);
    wait_done("t6_done", 2000);
    check("t6_nstb", 32'(n_stb - s0), 32'd32);
    check("t6_q", 32'(exp_q.size()), 32'd0);

    // Every group disabled: 8 samples at 2 cycles each, no strobes.
    set_flg(4'b1111);
    s0 = n_stb; b0 = n_busy;
    run_stb(4);
    wait_done("t6f_done", 400);
    check("t6f_nstb", 32'(n_stb - s0), 32'd0);
    check("t6f_busy", 32'(n_busy - b0), 32'd19);
    check("t6f_wptr", 32'(bus.addr_o), 32'd2);
    rdy_rand = 1'b0;

    // Asynchronous reset in the middle of a readout.
    set_flg(4'b0000);
    s0 = n_stb; d0 = n_done;
    push_read(5, 8, 4'b0000);
    run_then(4);
    k = 0;
    while (n_stb == s0 && k < 100) begin
      tick();
      k++;
    end
    check("t1_reached_read", 32'(n_stb != s0), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    last_sel = '0;
    #1;
    check("t1_txstb", 32'(bus.tx_stb_o), 32'd0);
    check("t1_we", 32'(bus.we_o), 32'd0);
    check("t1_busy", 32'(bus.busy_o), 32'd0);
    check("t1_addr", 32'(bus.addr_o), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("t1_no_done", 32'(n_done - d0), 32'd0);
    check("t1_idle", 32'(bus.busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
